// File: rtl/voxel_cls_pkg.sv
// Shared types and sizing for the voxel-bin gesture classifier.
package voxel_cls_pkg;

    localparam int NUM_CLASSES = 4;
    localparam int WEIGHT_BITS = 8;
    localparam int COUNT_BITS  = 4;
    localparam int ACC_BITS    = 24;
    localparam int CLS_IDX_W   = $clog2(NUM_CLASSES);

    typedef enum logic [CLS_IDX_W-1:0] {CLS_UP, CLS_DOWN, CLS_LEFT, CLS_RIGHT} class_e;

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_COMPARE, S_DONE} sched_state_e;

    typedef logic signed [ACC_BITS-1:0] acc_t;

endpackage

// File: rtl/cls_mac_acc.sv
// One signed count*weight accumulator; synchronous clear wins over enable.
module cls_mac_acc
    import voxel_cls_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr_i,
    input  logic                          en_i,
    input  logic [COUNT_BITS-1:0]         count_i,
    input  logic signed [WEIGHT_BITS-1:0] weight_i,
    output acc_t                          acc_o
);

    logic signed [COUNT_BITS+WEIGHT_BITS:0] prod;
    acc_t acc_q;

    // count is unsigned, so a zero MSB keeps it non-negative in the signed product
    assign prod = $signed({1'b0, count_i}) * weight_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (clr_i) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_q + acc_t'(prod);
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/voxel_classify_sched.sv
// Voxel-bin classifier sequencer: address walk, per-class MAC, argmax, valid/ready result.
// Optional CLS_REJECT_EN adds a below-threshold reject flag on the result.
module voxel_classify_sched
    import voxel_cls_pkg::*;
#(
    parameter int NUM_CELLS = 1024
`ifdef CLS_REJECT_EN
   ,parameter int SCORE_THRESH = 2000
`endif
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    output logic                                busy,
    output logic [$clog2(NUM_CELLS)-1:0]        cell_addr,
    input  logic [COUNT_BITS-1:0]               voxel_count,
    input  logic [NUM_CLASSES*WEIGHT_BITS-1:0]  weight_in,
    output logic                                result_valid,
    input  logic                                result_ready,
    output logic [CLS_IDX_W-1:0]                result_class,
    output logic signed [ACC_BITS-1:0]          result_score,
    output logic                                result_reject
);

    localparam int ADDR_W = $clog2(NUM_CELLS);
    localparam logic [ADDR_W-1:0]    LAST_ADDR = ADDR_W'(NUM_CELLS - 1);
    localparam logic [CLS_IDX_W-1:0] LAST_CLS  = CLS_IDX_W'(NUM_CLASSES - 1);

    sched_state_e          state_q, state_d;
    logic [ADDR_W-1:0]     cell_addr_q;
    logic                  last_q;
    logic                  mac_vld_p0_q;
    logic [CLS_IDX_W-1:0]  cmp_idx_q;
    acc_t                  best_q;
    class_e                best_cls_q;
    logic                  result_valid_q;
    class_e                result_class_q;
    acc_t                  result_score_q;

    acc_t   acc_w [NUM_CLASSES];
    acc_t   cand, best_nx;
    class_e cls_nx;
    logic   take, frame_go, cmp_fin;

    assign frame_go = (state_q == S_IDLE) && start;
    assign cmp_fin  = (state_q == S_COMPARE) && (cmp_idx_q == LAST_CLS);

    for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_acc
        cls_mac_acc u_acc (
            .clk      (clk),
            .rst_n    (rst_n),
            .clr_i    (frame_go),
            .en_i     (mac_vld_p0_q),
            .count_i  (voxel_count),
            .weight_i (weight_in[k*WEIGHT_BITS +: WEIGHT_BITS]),
            .acc_o    (acc_w[k])
        );
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start)        state_d = S_RUN;
            S_RUN:     if (last_q)       state_d = S_DRAIN;
            S_DRAIN:                     state_d = S_COMPARE;
            S_COMPARE: if (cmp_fin)      state_d = S_DONE;
            S_DONE:    if (result_ready) state_d = S_IDLE;
            default:                     state_d = S_IDLE;
        endcase
    end

    // Class 0 always seeds the running best; later classes replace it only when strictly greater
    always_comb begin
        cand    = acc_w[cmp_idx_q];
        take    = (cmp_idx_q == '0) || (cand > best_q);
        best_nx = take ? cand : best_q;
        cls_nx  = take ? class_e'(cmp_idx_q) : best_cls_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            cell_addr_q    <= '0;
            last_q         <= 1'b0;
            mac_vld_p0_q   <= 1'b0;
            cmp_idx_q      <= '0;
            best_q         <= '0;
            best_cls_q     <= CLS_UP;
            result_valid_q <= 1'b0;
            result_class_q <= CLS_UP;
            result_score_q <= '0;
        end else begin
            state_q <= state_d;
            // Address k is on the bus one cycle, its RAM/ROM data the next; the MAC takes it on the edge after
            last_q       <= (state_q == S_RUN) && (cell_addr_q == LAST_ADDR) && !last_q;
            mac_vld_p0_q <= (state_q == S_RUN) && !last_q;

            if (frame_go) begin
                cell_addr_q <= '0;
            end else if ((state_q == S_RUN) && (cell_addr_q != LAST_ADDR)) begin
                cell_addr_q <= cell_addr_q + ADDR_W'(1);
            end

            if (state_q == S_DRAIN) begin
                cmp_idx_q <= '0;
            end else if (state_q == S_COMPARE) begin
                cmp_idx_q  <= cmp_idx_q + CLS_IDX_W'(1);
                best_q     <= best_nx;
                best_cls_q <= cls_nx;
            end

            if (cmp_fin) begin
                result_valid_q <= 1'b1;
                result_class_q <= cls_nx;
                result_score_q <= best_nx;
            end else if ((state_q == S_DONE) && result_ready) begin
                result_valid_q <= 1'b0;
            end
        end
    end

`ifdef CLS_REJECT_EN
    localparam acc_t THRESH = acc_t'(SCORE_THRESH);
    logic reject_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reject_q <= 1'b0;
        end else if (cmp_fin) begin
            reject_q <= (best_nx < THRESH);
        end
    end

    assign result_reject = reject_q;
`else
    assign result_reject = 1'b0;
`endif

    assign busy         = (state_q != S_IDLE);
    assign cell_addr    = cell_addr_q;
    assign result_valid = result_valid_q;
    assign result_class = result_class_q;
    assign result_score = result_score_q;

endmodule

// File: tb/tb_voxel_classify_sched.sv
// Randomized bench for voxel_classify_sched against a sum-of-products argmax reference model.
module tb_voxel_classify_sched;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic               busy;
    logic [9:0]         cell_addr;
    logic [3:0]         voxel_count;
    logic [31:0]        weight_in;
    logic               result_valid;
    logic               result_ready;
    logic [1:0]         result_class;
    logic signed [23:0] result_score;
    logic               result_reject;

    logic [3:0]         mem [1024];
    logic signed [7:0]  rom [4][1024];

    int errors = 0;
    int checks = 0;

    voxel_classify_sched dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .busy          (busy),
        .cell_addr     (cell_addr),
        .voxel_count   (voxel_count),
        .weight_in     (weight_in),
        .result_valid  (result_valid),
        .result_ready  (result_ready),
        .result_class  (result_class),
        .result_score  (result_score),
        .result_reject (result_reject)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM and ROMs: data for an address appears one cycle after it is presented
    always @(posedge clk) begin
        voxel_count <= mem[cell_addr];
        for (int c = 0; c < 4; c++) weight_in[c*8 +: 8] <= rom[c][cell_addr];
    end

    task automatic chk_val(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int pat_w(input int c, input int a);
        int cx, cy;
        cx = a % 16;
        cy = (a / 16) % 16;
        case (c)
            0:       return (cy < 8)  ? 12 * (8 - cy) : -8 * (cy - 7);
            1:       return (cy >= 8) ? 12 * (cy - 7) : -8 * (8 - cy);
            2:       return (cx < 8)  ? 12 * (8 - cx) : -8 * (cx - 7);
            default: return (cx >= 8) ? 12 * (cx - 7) : -8 * (8 - cx);
        endcase
    endfunction

    task automatic load_pattern_rom();
        for (int c = 0; c < 4; c++)
            for (int a = 0; a < 1024; a++) rom[c][a] = 8'(pat_w(c, a));
    endtask

    task automatic clear_mem();
        for (int a = 0; a < 1024; a++) mem[a] = 4'd0;
    endtask

    task automatic run_frame(input string tag, input int hold, input bit poke);
        longint sc [4];
        longint best;
        int     bi;
        int     n;
        bit     got;
        bit     rej;
        for (int c = 0; c < 4; c++) begin
            sc[c] = 0;
            for (int a = 0; a < 1024; a++) sc[c] += longint'(mem[a]) * longint'(rom[c][a]);
        end
        bi = 0;
        best = sc[0];
        for (int c = 1; c < 4; c++) if (sc[c] > best) begin best = sc[c]; bi = c; end
`ifdef CLS_REJECT_EN
        rej = (best < 2000);
`else
        rej = 1'b0;
`endif
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        got = 1'b0;
        while (n < 1100 && !got) begin
            @(posedge clk);
            n++;
            #1;
            if (n == 1) begin
                chk_val({tag, ".busy_run"}, busy, 1);
                chk_val({tag, ".addr1"}, cell_addr, 1);
            end
            if (n == 1024) chk_val({tag, ".addr_last"}, cell_addr, 1023);
            if (result_valid) got = 1'b1;
        end
        chk_val({tag, ".latency"}, n, 1030);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            if (poke) start = (i == hold / 2);
        end
        start = 1'b0;
        chk_val({tag, ".valid"}, result_valid, 1);
        chk_val({tag, ".class"}, result_class, bi);
        chk_val({tag, ".score"}, result_score, best);
        chk_val({tag, ".reject"}, result_reject, rej);
        result_ready = 1'b1;
        @(posedge clk);
        #1 result_ready = 1'b0;
        chk_val({tag, ".valid_drop"}, result_valid, 0);
        chk_val({tag, ".busy_drop"}, busy, 0);
        repeat (3) @(posedge clk);
        #1 chk_val({tag, ".idle_stays"}, busy, 0);
    endtask

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        result_ready = 1'b0;
        clear_mem();
        load_pattern_rom();
        repeat (3) @(posedge clk);
        #1;
        chk_val("rst.busy", busy, 0);
        chk_val("rst.valid", result_valid, 0);
        chk_val("rst.addr", cell_addr, 0);
        chk_val("rst.score", result_score, 0);
        chk_val("rst.class", result_class, 0);
        chk_val("rst.reject", result_reject, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_frame("zero", 0, 1'b0);

        for (int a = 0; a < 128; a++) mem[a] = 4'd1;
        run_frame("rows_up", 2, 1'b0);

        clear_mem();
        for (int a = 0; a < 1024; a++) if ((a % 16) >= 8) mem[a] = 4'd1;
        run_frame("right_all", 50, 1'b1);

        clear_mem();
        mem[0] = 4'd1;
        run_frame("single", 1, 1'b0);

        // Abort a frame with reset partway through the address walk
        for (int a = 0; a < 1024; a++) mem[a] = 4'($urandom_range(0, 15));
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (500) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk_val("abort.busy", busy, 0);
        chk_val("abort.addr", cell_addr, 0);
        chk_val("abort.valid", result_valid, 0);
        chk_val("abort.score", result_score, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        clear_mem();
        for (int a = 0; a < 1024; a++) if ((a % 16) < 8 && $urandom_range(0, 3) == 0) mem[a] = 4'($urandom_range(1, 15));
        run_frame("after_abort", 3, 1'b0);

        for (int f = 0; f < 3; f++) begin
            for (int a = 0; a < 1024; a++) mem[a] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
            run_frame($sformatf("rand%0d", f), $urandom_range(0, 5), 1'b1);
        end

        for (int c = 0; c < 4; c++)
            for (int a = 0; a < 1024; a++) rom[c][a] = 8'($urandom_range(0, 255));
        for (int a = 0; a < 1024; a++) mem[a] = 4'($urandom_range(0, 15));
        run_frame("rand_rom", 4, 1'b0);

        for (int c = 0; c < 4; c++)
            for (int a = 0; a < 1024; a++) rom[c][a] = 8'sd5;
        run_frame("tie_all", 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
